uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
Stand-alone 8N1 UART receiver for the Zedboard lab designs. It deserialises the asynchronous rx line into bytes and holds each byte in a one-entry holding register until the consumer acknowledges it. It also flags framing errors and overruns. It pairs with the existing lab UART transmitter, either in loopback (tx_o wired to rx_i) or from the USB-UART bridge.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud); minimum 4.
- SYNC_STAGES, 2, number of flip-flops in the rx input synchroniser; minimum 2.

Ports:
- clk_i  in  1  system clock (100 MHz).
- rst_ni  in  1  reset, asynchronous, active-low.
- rx_i  in  1  serial input; idles high.
- rd_i  in  1  consumer acknowledge; clears rdy_o and overrun_o.
- data_o  out  8  last correctly framed byte.
- rdy_o  out  1  holding register contains an unread byte.
- valid_o  out  1  one-cycle pulse when a new byte is loaded into data_o.
- frame_err_o  out  1  one-cycle pulse when the stop bit samples low.
- overrun_o  out  1  sticky: a byte arrived while rdy_o was still 1.
- busy_o  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async, rst_ni=0):
  - synchroniser flops = 1; FSM = IDLE; counters = 0; shift register = 0.
  - data_o = 8'h00; rdy_o, valid_o, frame_err_o, overrun_o, busy_o = 0.
- Synchroniser: rx_s is rx_i delayed by SYNC_STAGES cycles. All sampling below uses rx_s.
- Bit counter: cnt counts down. It reloads on each state entry, and the sample point is the cycle where cnt==0.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with cnt=CLKS_PER_BIT/2-1 (integer division).
  - START, at cnt==0 (mid start bit):
    - rx_s==0: go to DATA, cnt=CLKS_PER_BIT-1, bit_idx=0.
    - rx_s==1: treat as a glitch and return to IDLE; no outputs change.
  - DATA, at cnt==0:
    - shift right with rx_s into bit 7 (LSB first on the wire); bit_idx++.
    - after bit_idx reaches 7 and that bit is sampled, go to STOP with cnt=CLKS_PER_BIT-1.
  - STOP, at cnt==0:
    - rx_s==1: data_o<=shift register, valid_o=1 for that cycle, rdy_o<=1, go to IDLE.
    - rx_s==0: frame_err_o=1 for that cycle; data_o and rdy_o unchanged; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line (break) from being re-read as a stream of 0x00 frames.
- Latency: valid_o rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+1) cycles after the falling start edge on rx_i. That is mid stop bit; the receiver is ready for the next start bit at once.
- Holding register / handshake:
  - rd_i while rdy_o==1: clears rdy_o and overrun_o on the next edge.
  - rd_i while rdy_o==0: no effect.
- Overrun:
  - a good stop bit while rdy_o==1 and rd_i==0 overwrites data_o with the new byte, sets overrun_o=1, pulses valid_o, and keeps rdy_o=1.
  - same cycle with rd_i==1: the load wins (rdy_o stays 1) and overrun_o stays 0.
- busy_o = (state != IDLE), registered with the state.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is discarded; receive restarts on the next falling edge after release.
- Widths:
  - cnt is $clog2(CLKS_PER_BIT) bits.
  - bit_idx is 3 bits. It wraps 7->0 only via the STOP transition and is never compared beyond 7.

Decomposition:
- Shared package uart_pkg:
  - state enum rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - localparams DATA_BITS=8, DEFAULT_CLKS_PER_BIT=868.
  - The lab UART transmitter reuses the constants.
- One sub-module, uart_sync (SYNC_STAGES-deep synchroniser with reset value 1). Everything else stays in uart_rx_8n1.

Test Plan:
Run all scenarios with CLKS_PER_BIT=16 for speed. The line is driven by a bench task unless stated otherwise.
1. Frame 0x41 (start, bits 1,0,0,0,0,0,1,0, stop) -> data_o=8'h41, valid_o high exactly 1 cycle, rdy_o=1, frame_err_o=0; rd_i pulse -> rdy_o=0.
2. rx_i low for 5 cycles (< 8 = half bit) then high -> no valid_o, no frame_err_o, busy_o returns to 0 within 8 cycles, data_o unchanged.
3. Frame 0x55 with stop bit driven 0, line held low 40 cycles -> frame_err_o single pulse, data_o keeps previous 0x41, no second frame decoded while low; after line goes high, frame 0x3C -> data_o=8'h3C.
4. Back-to-back 0x41 then 0x42, no rd_i -> second valid_o pulse, data_o=8'h42, rdy_o=1, overrun_o=1; rd_i -> rdy_o=0, overrun_o=0.
5. Assert rst_ni=0 mid DATA of frame 0xA5 -> all outputs 0 asynchronously; release, then send 0x5A -> data_o=8'h5A, overrun_o=0.
6. Loopback with the lab transmitter at CLKS_PER_BIT=868, switches=8'h41, send pulsed -> data_o=8'h41 and rdy_o=1 roughly 9.5 bit times (about 8250 cycles) after tx start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and receiver state encoding.
// The lab transmitter imports the same constants.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous input that idles high.
// Resets to 1 so a line held in reset does not look like a start bit.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-entry holding register, framing-error and overrun flags.
// Bits are sampled mid-period using a down-counter that reloads on every state entry.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 rdy_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .d    (rx_i),
        .q    (rx_s)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_o      <= '0;
            rdy_o       <= 1'b0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;

            // Consumer ack; a simultaneous load below overrides rdy_o.
            if (rd_i && rdy_o) begin
                rdy_o     <= 1'b0;
                overrun_o <= 1'b0;
            end

            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= CNT_HALF;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        cnt       <= CNT_FULL;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            data_o  <= shift_reg;
                            valid_o <= 1'b1;
                            rdy_o   <= 1'b1;
                            if (rdy_o && !rd_i) begin
                                overrun_o <= 1'b1;
                            end
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a break is not read as 0x00 frames.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Randomised self-checking bench for uart_rx_8n1 against a frame-level reference model.
// A second instance at the default bit rate stands in for the loopback case.
module tb_uart_rx_8n1;

    localparam int FAST_CPB  = 16;
    localparam int FAST_HALF = FAST_CPB / 2;
    localparam int SLOW_CPB  = 868;
    localparam int SYNC      = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx, rd, rx_sl, rd_sl;
    logic [7:0] data, data_sl;
    logic       rdy, valid, ferr, ovr, busy;
    logic       rdy_sl, valid_sl, ferr_sl, ovr_sl, busy_sl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt = 0, fcnt = 0, lat = 0, start_cyc = 0;
    int vcnt_s = 0, lat_s = 0, start_cyc_s = 0;

    // Reference model state
    logic [7:0] m_data;
    logic       m_rdy, m_ovr;
    int         exp_v = 0, exp_f = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_8n1 #(.CLKS_PER_BIT(FAST_CPB), .SYNC_STAGES(SYNC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .rd_i(rd), .data_o(data), .rdy_o(rdy),
        .valid_o(valid), .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(SLOW_CPB), .SYNC_STAGES(SYNC)) u_dut_slow (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_sl), .rd_i(rd_sl), .data_o(data_sl),
        .rdy_o(rdy_sl), .valid_o(valid_sl), .frame_err_o(ferr_sl), .overrun_o(ovr_sl),
        .busy_o(busy_sl)
    );

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            lat = cyc - start_cyc;
        end
        if (ferr) fcnt++;
        if (valid_sl) begin
            vcnt_s++;
            lat_s = cyc - start_cyc_s;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller must be at posedge+1. rd_on_load raises rd_i for the stop-bit sampling edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit rd_on_load,
                              input int low_tail, input bit slow);
        logic [9:0] bits;
        int cpb;
        bits = {stop_bit, b, 1'b0};
        cpb  = slow ? SLOW_CPB : FAST_CPB;
        if (slow) start_cyc_s = cyc;
        else start_cyc = cyc;
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < cpb; c++) begin
                if (slow) rx_sl = bits[n];
                else rx = bits[n];
                if (!slow) rd = rd_on_load && (n == 9) && (c == FAST_HALF + 2);
                @(posedge clk);
                #1;
            end
        end
        rd = 1'b0;
        idle(low_tail);
        if (slow) rx_sl = 1'b1;
        else rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good, input bit rd_on_load);
        if (!good) begin
            exp_f++;
        end else begin
            exp_v++;
            if (rd_on_load) begin
                if (m_rdy) m_ovr = 1'b0;
            end else if (m_rdy) begin
                m_ovr = 1'b1;
            end
            m_rdy  = 1'b1;
            m_data = b;
        end
    endtask

    task automatic read_ack();
        rd = 1'b1;
        idle(1);
        rd = 1'b0;
        if (m_rdy) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".data"}, 32'(data), 32'(m_data));
        check({tag, ".rdy"}, 32'(rdy), 32'(m_rdy));
        check({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
        check({tag, ".vcnt"}, vcnt, exp_v);
        check({tag, ".fcnt"}, fcnt, exp_f);
    endtask

    task automatic model_reset();
        m_data = 8'h00;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit         err, rdl;
        int         fast_lat;
        fast_lat = SYNC + FAST_CPB / 2 + 9 * FAST_CPB + 1;

        rst_n = 1'b0; rx = 1'b1; rd = 1'b0; rx_sl = 1'b1; rd_sl = 1'b0;
        model_reset();
        idle(3);
        check("reset.busy", 32'(busy), 0);
        check("reset.valid", 32'(valid), 0);
        check("reset.ferr", 32'(ferr), 0);
        check_state("reset");
        rst_n = 1'b1;
        idle(3);

        // Single good frame, then acknowledge
        send_frame(8'h41, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h41, 1'b1, 1'b0);
        idle(4);
        check_state("f41");
        check("f41.lat", lat, fast_lat);
        check("f41.busy", 32'(busy), 0);
        read_ack();
        check("f41.ack_rdy", 32'(rdy), 32'(m_rdy));

        // Start-bit glitch shorter than half a bit
        rx = 1'b0;
        idle(3);
        check("glitch.busy_hi", 32'(busy), 1);
        idle(2);
        rx = 1'b1;
        idle(12);
        check("glitch.busy_lo", 32'(busy), 0);
        check_state("glitch");

        // Bad stop bit followed by a held-low break
        send_frame(8'h55, 1'b0, 1'b0, 40, 1'b0);
        model_frame(8'h55, 1'b0, 1'b0);
        check("brk.busy_hi", 32'(busy), 1);
        check_state("brk");
        idle(5);
        check("brk.busy_lo", 32'(busy), 0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        check_state("f3c");
        read_ack();

        // Back-to-back without acknowledge gives overrun
        send_frame(8'h41, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h41, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h42, 1'b1, 1'b0);
        idle(4);
        check_state("ovr");
        read_ack();
        check_state("ovr_ack");

        // Acknowledge on the load cycle: load wins, no overrun
        send_frame(8'h99, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h99, 1'b1, 1'b0);
        send_frame(8'h17, 1'b1, 1'b1, 0, 1'b0);
        model_frame(8'h17, 1'b1, 1'b1);
        idle(4);
        check_state("rdload");

        // Reset in the middle of frame 0xA5
        rx = 1'b0;
        idle(FAST_CPB);
        rx = 1'b1;
        idle(FAST_CPB);
        rx = 1'b0;
        idle(FAST_CPB + 3);
        check("rstmid.busy_hi", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid.busy", 32'(busy), 0);
        check("rstmid.data", 32'(data), 0);
        check("rstmid.rdy", 32'(rdy), 0);
        check("rstmid.ovr", 32'(ovr), 0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0);
        idle(4);
        check_state("f5a");

        // Randomised frames, errors, acks and gaps
        for (int i = 0; i < 16; i++) begin
            b   = 8'($urandom_range(0, 255));
            err = ($urandom_range(0, 5) == 0);
            rdl = !err && ($urandom_range(0, 3) == 0);
            send_frame(b, !err, rdl, err ? int'($urandom_range(0, 20)) : 0, 1'b0);
            model_frame(b, !err, rdl);
            idle(int'($urandom_range(3, 12)));
            check_state("rnd");
            if (!err) check("rnd.lat", lat, fast_lat);
            if ($urandom_range(0, 1) == 1) begin
                read_ack();
                check("rnd.ack_rdy", 32'(rdy), 32'(m_rdy));
                check("rnd.ack_ovr", 32'(ovr), 32'(m_ovr));
            end
        end

        // Default bit rate, as seen from the lab transmitter
        send_frame(8'h41, 1'b1, 1'b0, 0, 1'b1);
        idle(10);
        check("slow.data", 32'(data_sl), 32'h41);
        check("slow.rdy", 32'(rdy_sl), 1);
        check("slow.vcnt", vcnt_s, 1);
        check("slow.lat", lat_s, SYNC + SLOW_CPB / 2 + 9 * SLOW_CPB + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
